// File: rtl/tx_sequence_modulator_if.sv
// +----------------------------------------------------------------------------+
// | tx_sequence_modulator_if : ARM control / DAC sample bus of the TX modulator |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface tx_sequence_modulator_if;
  logic               etx_en;
  logic               istart_tx;
  logic [3:0]         iseq_select;
  logic [31:0]        icurrent_time;
  logic               inew_sample_trigger;
  logic               iresult_acquired;
  logic signed [15:0] o_sample;
  logic               o_sample_valid;
  logic               o_busy;
  logic [3:0]         o_tx_seq;
  logic [31:0]        o_time_arm;
  logic               o_trigger_arm;

  modport master (
    output etx_en, istart_tx, iseq_select, icurrent_time,
           inew_sample_trigger, iresult_acquired,
    input  o_sample, o_sample_valid, o_busy, o_tx_seq, o_time_arm, o_trigger_arm
  );

  modport slave (
    input  etx_en, istart_tx, iseq_select, icurrent_time,
           inew_sample_trigger, iresult_acquired,
    output o_sample, o_sample_valid, o_busy, o_tx_seq, o_time_arm, o_trigger_arm
  );
endinterface

`default_nettype wire

// File: rtl/tx_sequence_modulator.sv
// +----------------------------------------------------------------------------+
// | tx_sequence_modulator : LFSR chip sequence BPSK-modulated on a square wave  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tx_sequence_modulator #(
  parameter int CHIP_COUNT       = 255,
  parameter int SAMPLES_PER_CHIP = 80,
  parameter int CARRIER_HALF     = 4,
  parameter int AMPLITUDE        = 8000
) (
  input  logic                    ctx_clk,
  input  logic                    rtx_rst_n,
  tx_sequence_modulator_if.slave  tx_if
);

  localparam int SCW = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
  localparam int CCW = $clog2(2 * CARRIER_HALF);

  localparam logic [SCW-1:0]     SPC_LAST  = SCW'(SAMPLES_PER_CHIP - 1);
  localparam logic [CCW-1:0]     CAR_LAST  = CCW'(2 * CARRIER_HALF - 1);
  localparam logic [CCW-1:0]     CAR_HALF  = CCW'(CARRIER_HALF);
  localparam logic [7:0]         CHIP_LAST = 8'(CHIP_COUNT - 1);
  localparam logic signed [15:0] AMP_POS   = 16'(AMPLITUDE);
  localparam logic signed [15:0] AMP_NEG   = 16'(-AMPLITUDE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TX    = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [SCW-1:0]     sample_cnt_q, sample_cnt_d;
  logic [7:0]         chip_cnt_q, chip_cnt_d;
  logic [CCW-1:0]     carrier_cnt_q, carrier_cnt_d;
  logic               first_q, first_d;
  logic signed [15:0] sample_q, sample_d;
  logic               valid_q, valid_d;
  logic [3:0]         seq_q, seq_d;
  logic [31:0]        time_q, time_d;
  logic               trig_q, trig_d;

  logic       carrier_neg;
  logic [7:0] lfsr_next;

  assign carrier_neg = (carrier_cnt_q >= CAR_HALF);
  assign lfsr_next   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};

  always_ff @(posedge ctx_clk or negedge rtx_rst_n) begin
    if (!rtx_rst_n) begin
      state_q       <= S_IDLE;
      lfsr_q        <= '0;
      sample_cnt_q  <= '0;
      chip_cnt_q    <= '0;
      carrier_cnt_q <= '0;
      first_q       <= 1'b0;
      sample_q      <= '0;
      valid_q       <= 1'b0;
      seq_q         <= '0;
      time_q        <= '0;
      trig_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      sample_cnt_q  <= sample_cnt_d;
      chip_cnt_q    <= chip_cnt_d;
      carrier_cnt_q <= carrier_cnt_d;
      first_q       <= first_d;
      sample_q      <= sample_d;
      valid_q       <= valid_d;
      seq_q         <= seq_d;
      time_q        <= time_d;
      trig_q        <= trig_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    sample_cnt_d  = sample_cnt_q;
    chip_cnt_d    = chip_cnt_q;
    carrier_cnt_d = carrier_cnt_q;
    first_d       = first_q;
    sample_d      = sample_q;
    valid_d       = 1'b0;
    seq_d         = seq_q;
    time_d        = time_q;
    // Acknowledge clears first; a FLUSH completion below re-sets it (set wins).
    trig_d        = trig_q & ~tx_if.iresult_acquired;

    if (!tx_if.etx_en) begin
      state_d       = S_IDLE;
      lfsr_d        = '0;
      sample_cnt_d  = '0;
      chip_cnt_d    = '0;
      carrier_cnt_d = '0;
      first_d       = 1'b0;
      sample_d      = '0;
      seq_d         = '0;
      time_d        = '0;
      trig_d        = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tx_if.inew_sample_trigger) begin
            sample_d = '0;
            valid_d  = 1'b1;
          end
          if (tx_if.istart_tx) begin
            seq_d         = tx_if.iseq_select;
            lfsr_d        = {tx_if.iseq_select, ~tx_if.iseq_select};
            sample_cnt_d  = '0;
            chip_cnt_d    = '0;
            carrier_cnt_d = '0;
            first_d       = 1'b0;
            state_d       = S_TX;
          end
        end
        S_TX: begin
          if (tx_if.inew_sample_trigger) begin
            sample_d = (lfsr_q[0] ^ carrier_neg) ? AMP_NEG : AMP_POS;
            valid_d  = 1'b1;
            if (!first_q) begin
              time_d  = tx_if.icurrent_time;
              first_d = 1'b1;
            end
            carrier_cnt_d = (carrier_cnt_q == CAR_LAST) ? '0 : carrier_cnt_q + 1'b1;
            if (sample_cnt_q == SPC_LAST) begin
              sample_cnt_d = '0;
              lfsr_d       = lfsr_next;
              chip_cnt_d   = chip_cnt_q + 8'd1;
              if (chip_cnt_q == CHIP_LAST) begin
                state_d = S_FLUSH;
              end
            end else begin
              sample_cnt_d = sample_cnt_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (tx_if.inew_sample_trigger) begin
            sample_d = '0;
            valid_d  = 1'b1;
            trig_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tx_if.o_sample       = sample_q;
  assign tx_if.o_sample_valid = valid_q;
  assign tx_if.o_busy         = (state_q != S_IDLE);
  assign tx_if.o_tx_seq       = seq_q;
  assign tx_if.o_time_arm     = time_q;
  assign tx_if.o_trigger_arm  = trig_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_sequence_modulator.sv
// +----------------------------------------------------------------------------+
// | tb_tx_sequence_modulator : directed bench, short-run and full-length DUTs   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_tx_sequence_modulator;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tx_sequence_modulator_if ifa ();
  tx_sequence_modulator_if ifb ();

  // Short transmission: 4 chips x 2 samples, carrier flips every sample.
  tx_sequence_modulator #(
    .CHIP_COUNT(4), .SAMPLES_PER_CHIP(2), .CARRIER_HALF(1), .AMPLITUDE(8000)
  ) dut_a (
    .ctx_clk(clk), .rtx_rst_n(rst_n), .tx_if(ifa.slave)
  );

  // Full-length sequence, one sample per chip.
  tx_sequence_modulator #(
    .CHIP_COUNT(255), .SAMPLES_PER_CHIP(1), .CARRIER_HALF(2), .AMPLITUDE(8000)
  ) dut_b (
    .ctx_clk(clk), .rtx_rst_n(rst_n), .tx_if(ifb.slave)
  );

  function automatic logic signed [15:0] exp_sample(input logic [3:0] seq, input int k,
                                                     input int spc, input int ch);
    logic [7:0] l;
    logic       neg;
    l = {seq, ~seq};
    for (int i = 0; i < k / spc; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[4], l[7:1]};
    neg = ((k % (2 * ch)) >= ch);
    return (l[0] ^ neg) ? -16'sd8000 : 16'sd8000;
  endfunction

  // One clock; single-cycle strobes are dropped again just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    ifa.inew_sample_trigger = 1'b0; ifb.inew_sample_trigger = 1'b0;
    ifa.istart_tx = 1'b0;           ifb.istart_tx = 1'b0;
    ifa.iresult_acquired = 1'b0;    ifb.iresult_acquired = 1'b0;
  endtask

  task automatic test_reset();
    ifa.etx_en = 1'b1; ifa.istart_tx = 1'b0; ifa.iseq_select = '0; ifa.icurrent_time = '0;
    ifa.inew_sample_trigger = 1'b0; ifa.iresult_acquired = 1'b0;
    ifb.etx_en = 1'b1; ifb.istart_tx = 1'b0; ifb.iseq_select = '0; ifb.icurrent_time = '0;
    ifb.inew_sample_trigger = 1'b0; ifb.iresult_acquired = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    checks++;
    if (ifa.o_sample !== 16'sd0 || ifa.o_sample_valid !== 1'b0 || ifa.o_busy !== 1'b0 ||
        ifa.o_tx_seq !== 4'd0 || ifa.o_time_arm !== 32'd0 || ifa.o_trigger_arm !== 1'b0) begin
      failures++;
      $display("FAIL reset_a sample=%0d valid=%b busy=%b seq=%0d time=%0d trig=%b expected all 0",
               ifa.o_sample, ifa.o_sample_valid, ifa.o_busy, ifa.o_tx_seq, ifa.o_time_arm, ifa.o_trigger_arm);
    end
    checks++;
    if (ifb.o_busy !== 1'b0 || ifb.o_trigger_arm !== 1'b0 || ifb.o_sample !== 16'sd0) begin
      failures++;
      $display("FAIL reset_b busy=%b trig=%b sample=%0d expected 0", ifb.o_busy, ifb.o_trigger_arm, ifb.o_sample);
    end
  endtask

  task automatic test_first_sample();
    ifa.iseq_select = 4'd0; ifa.istart_tx = 1'b1;
    step();
    checks++;
    if (ifa.o_busy !== 1'b1 || ifa.o_tx_seq !== 4'd0) begin
      failures++;
      $display("FAIL start_busy busy=%b seq=%0d expected busy=1 seq=0", ifa.o_busy, ifa.o_tx_seq);
    end
    ifa.icurrent_time = 32'd1000; ifa.inew_sample_trigger = 1'b1;
    step();
    checks++;
    if (ifa.o_sample !== -16'sd8000 || ifa.o_sample_valid !== 1'b1 || ifa.o_time_arm !== 32'd1000) begin
      failures++;
      $display("FAIL first_sample sample=%0d valid=%b time=%0d expected -8000 1 1000",
               ifa.o_sample, ifa.o_sample_valid, ifa.o_time_arm);
    end
    ifa.icurrent_time = 32'd1001;
    step();
    checks++;
    if (ifa.o_sample_valid !== 1'b0 || ifa.o_sample !== -16'sd8000) begin
      failures++;
      $display("FAIL idle_hold valid=%b sample=%0d expected 0 -8000", ifa.o_sample_valid, ifa.o_sample);
    end
    ifa.inew_sample_trigger = 1'b1;
    step();
    checks++;
    if (ifa.o_sample !== 16'sd8000 || dut_a.lfsr_q !== 8'h87 || ifa.o_time_arm !== 32'd1000) begin
      failures++;
      $display("FAIL second_sample sample=%0d lfsr=%h time=%0d expected 8000 87 1000",
               ifa.o_sample, dut_a.lfsr_q, ifa.o_time_arm);
    end
    for (int k = 2; k < 8; k++) begin
      ifa.inew_sample_trigger = 1'b1;
      step();
      checks++;
      if (ifa.o_sample !== exp_sample(4'd0, k, 2, 1) || ifa.o_sample_valid !== 1'b1) begin
        failures++;
        $display("FAIL seq0_sample k=%0d got=%0d valid=%b expected=%0d", k, ifa.o_sample,
                 ifa.o_sample_valid, exp_sample(4'd0, k, 2, 1));
      end
    end
    checks++;
    if (ifa.o_busy !== 1'b1 || ifa.o_trigger_arm !== 1'b0) begin
      failures++;
      $display("FAIL flush_wait busy=%b trig=%b expected 1 0", ifa.o_busy, ifa.o_trigger_arm);
    end
    ifa.inew_sample_trigger = 1'b1;
    step();
    checks++;
    if (ifa.o_sample !== 16'sd0 || ifa.o_sample_valid !== 1'b1 || ifa.o_trigger_arm !== 1'b1 || ifa.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL flush sample=%0d valid=%b trig=%b busy=%b expected 0 1 1 0",
               ifa.o_sample, ifa.o_sample_valid, ifa.o_trigger_arm, ifa.o_busy);
    end
  endtask

  task automatic test_full_run();
    int nz;
    nz = 0;
    ifb.iseq_select = 4'd5; ifb.istart_tx = 1'b1;
    step();
    for (int k = 0; k < 255; k++) begin
      ifb.inew_sample_trigger = 1'b1;
      step();
      if (ifb.o_sample_valid === 1'b1 && ifb.o_sample !== 16'sd0) nz++;
      checks++;
      if (ifb.o_sample !== exp_sample(4'd5, k, 1, 2) || ifb.o_sample_valid !== 1'b1) begin
        failures++;
        $display("FAIL full_sample k=%0d got=%0d valid=%b expected=%0d", k, ifb.o_sample,
                 ifb.o_sample_valid, exp_sample(4'd5, k, 1, 2));
      end
    end
    checks++;
    if (nz !== 255 || dut_b.lfsr_q !== 8'h5A || ifb.o_busy !== 1'b1 || ifb.o_trigger_arm !== 1'b0) begin
      failures++;
      $display("FAIL full_count nonzero=%0d lfsr=%h busy=%b trig=%b expected 255 5a 1 0",
               nz, dut_b.lfsr_q, ifb.o_busy, ifb.o_trigger_arm);
    end
    ifb.inew_sample_trigger = 1'b1;
    step();
    checks++;
    if (ifb.o_sample !== 16'sd0 || ifb.o_sample_valid !== 1'b1 || ifb.o_trigger_arm !== 1'b1) begin
      failures++;
      $display("FAIL full_flush sample=%0d valid=%b trig=%b expected 0 1 1",
               ifb.o_sample, ifb.o_sample_valid, ifb.o_trigger_arm);
    end
  endtask

  task automatic test_handshake();
    for (int c = 0; c < 50; c++) begin
      step();
      checks++;
      if (ifb.o_trigger_arm !== 1'b1) begin
        failures++;
        $display("FAIL trig_hold cycle=%0d got=%b expected 1", c, ifb.o_trigger_arm);
      end
    end
    ifb.iresult_acquired = 1'b1;
    step();
    checks++;
    if (ifb.o_trigger_arm !== 1'b0) begin
      failures++;
      $display("FAIL trig_ack got=%b expected 0", ifb.o_trigger_arm);
    end
  endtask

  task automatic test_retrigger_same_cycle();
    ifa.iseq_select = 4'd6; ifa.istart_tx = 1'b1;
    step();
    ifa.icurrent_time = 32'd2000; ifa.inew_sample_trigger = 1'b1;
    step();
    checks++;
    if (ifa.o_time_arm !== 32'd2000 || ifa.o_trigger_arm !== 1'b1 || ifa.o_sample !== exp_sample(4'd6, 0, 2, 1)) begin
      failures++;
      $display("FAIL retrigger time=%0d trig=%b sample=%0d expected 2000 1 %0d",
               ifa.o_time_arm, ifa.o_trigger_arm, ifa.o_sample, exp_sample(4'd6, 0, 2, 1));
    end
    for (int k = 1; k < 8; k++) begin
      ifa.inew_sample_trigger = 1'b1;
      step();
    end
    ifa.inew_sample_trigger = 1'b1; ifa.iresult_acquired = 1'b1;
    step();
    checks++;
    if (ifa.o_trigger_arm !== 1'b1 || ifa.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL set_wins trig=%b busy=%b expected 1 0", ifa.o_trigger_arm, ifa.o_busy);
    end
    ifa.iresult_acquired = 1'b1;
    step();
    checks++;
    if (ifa.o_trigger_arm !== 1'b0) begin
      failures++;
      $display("FAIL ack_a trig=%b expected 0", ifa.o_trigger_arm);
    end
  endtask

  task automatic test_busy_lockout();
    ifa.iseq_select = 4'd3; ifa.istart_tx = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      ifa.inew_sample_trigger = 1'b1;
      if (k == 2) begin
        ifa.istart_tx = 1'b1; ifa.iseq_select = 4'd9;
      end
      step();
      checks++;
      if (ifa.o_sample !== exp_sample(4'd3, k, 2, 1) || ifa.o_tx_seq !== 4'd3) begin
        failures++;
        $display("FAIL lockout k=%0d sample=%0d seq=%0d expected %0d 3", k, ifa.o_sample,
                 ifa.o_tx_seq, exp_sample(4'd3, k, 2, 1));
      end
    end
    ifa.inew_sample_trigger = 1'b1;
    step();
    checks++;
    if (ifa.o_trigger_arm !== 1'b1 || ifa.o_sample !== 16'sd0 || ifa.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL lockout_end trig=%b sample=%0d busy=%b expected 1 0 0",
               ifa.o_trigger_arm, ifa.o_sample, ifa.o_busy);
    end
  endtask

  task automatic test_enable_abort();
    ifa.iseq_select = 4'd12; ifa.istart_tx = 1'b1;
    step();
    repeat (3) begin
      ifa.inew_sample_trigger = 1'b1;
      step();
    end
    ifa.etx_en = 1'b0;
    step();
    ifa.etx_en = 1'b1;
    checks++;
    if (ifa.o_sample !== 16'sd0 || ifa.o_busy !== 1'b0 || ifa.o_trigger_arm !== 1'b0 ||
        ifa.o_tx_seq !== 4'd0 || ifa.o_time_arm !== 32'd0) begin
      failures++;
      $display("FAIL abort sample=%0d busy=%b trig=%b seq=%0d time=%0d expected all 0",
               ifa.o_sample, ifa.o_busy, ifa.o_trigger_arm, ifa.o_tx_seq, ifa.o_time_arm);
    end
    for (int c = 0; c < 20; c++) begin
      ifa.inew_sample_trigger = 1'b1;
      step();
      checks++;
      if (ifa.o_trigger_arm !== 1'b0 || ifa.o_busy !== 1'b0 || ifa.o_sample !== 16'sd0) begin
        failures++;
        $display("FAIL post_abort cycle=%0d trig=%b busy=%b sample=%0d expected 0 0 0",
                 c, ifa.o_trigger_arm, ifa.o_busy, ifa.o_sample);
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    ifa.iseq_select = 4'd1; ifa.istart_tx = 1'b1;
    step();
    ifa.icurrent_time = 32'd3000;
    for (int k = 0; k < 6; k++) begin
      ifa.inew_sample_trigger = 1'b1;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ifa.o_sample !== 16'sd0 || ifa.o_sample_valid !== 1'b0 || ifa.o_busy !== 1'b0 ||
        ifa.o_tx_seq !== 4'd0 || ifa.o_time_arm !== 32'd0 || ifa.o_trigger_arm !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_tx sample=%0d valid=%b busy=%b seq=%0d time=%0d trig=%b expected all 0",
               ifa.o_sample, ifa.o_sample_valid, ifa.o_busy, ifa.o_tx_seq, ifa.o_time_arm, ifa.o_trigger_arm);
    end
    #2 rst_n = 1'b1;
    ifa.inew_sample_trigger = 1'b1;
    step();
    checks++;
    if (ifa.o_busy !== 1'b0 || ifa.o_sample !== 16'sd0 || ifa.o_sample_valid !== 1'b1) begin
      failures++;
      $display("FAIL after_reset busy=%b sample=%0d valid=%b expected 0 0 1",
               ifa.o_busy, ifa.o_sample, ifa.o_sample_valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_full_run();
    test_handshake();
    test_retrigger_same_cycle();
    test_busy_lockout();
    test_enable_abort();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
